// File: rtl/flo_intr_ctrl_if.sv
// Register strobe bus between the S_AXI_INTR bridge and the interrupt controller.
// The bridge is the master; the controller is the slave.
interface flo_intr_ctrl_if;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
    input  reg_rd_data, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
    output reg_rd_data, reg_rd_valid
  );
endinterface

// File: rtl/flo_intr_ctrl.sv
// flocra interrupt controller: captures sequencer/buffer interrupt sources into
// ISR, masks them with IER and GIE, and drives a level or fixed-width pulse irq.
module flo_intr_ctrl #(
  parameter int unsigned C_NUM_OF_INTR      = 4,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
  parameter bit          C_IRQ_SENSITIVITY  = 1'b1,
  parameter bit          C_IRQ_ACTIVE_STATE = 1'b1,
  parameter int unsigned C_IRQ_PULSE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_NUM_OF_INTR-1:0] intr_in,
  flo_intr_ctrl_if.slave           bus,
  output logic                     irq
);

  localparam int unsigned N = C_NUM_OF_INTR;

  localparam logic [4:0] ADDR_GIE = 5'h00;
  localparam logic [4:0] ADDR_IER = 5'h04;
  localparam logic [4:0] ADDR_ISR = 5'h08;
  localparam logic [4:0] ADDR_IAR = 5'h0C;
  localparam logic [4:0] ADDR_IPR = 5'h10;

  // Bit set = rising-edge capture, bit clear = level capture.
  localparam logic [N-1:0] EDGE_MASK  = C_INTR_SENSITIVITY[N-1:0];
  localparam logic [7:0]   PULSE_LOAD = 8'(C_IRQ_PULSE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT
  } pulse_state_e;

  logic         gie_q;
  logic [N-1:0] ier_q;
  logic [N-1:0] isr_q;
  logic [N-1:0] prev_q;

  logic         wr_gie;
  logic         wr_ier;
  logic         wr_iar;
  logic [N-1:0] set_vec;
  logic [N-1:0] ack_vec;
  logic [N-1:0] ipr;
  logic         any_pend;
  logic [31:0]  rd_mux;

  pulse_state_e state_q;
  pulse_state_e state_d;
  logic [7:0]   cnt_q;
  logic [7:0]   cnt_d;
  logic         irq_active_d;

  // Only the low N bits of write data are stored; the rest are deliberately dropped.
  logic unused_wr_bits;
  assign unused_wr_bits = ^bus.reg_wr_data;

  // Write decode, capture/ack vectors and the pending summary from registered state.
  always_comb begin
    wr_gie   = bus.reg_wr_en && (bus.reg_wr_addr == ADDR_GIE);
    wr_ier   = bus.reg_wr_en && (bus.reg_wr_addr == ADDR_IER);
    wr_iar   = bus.reg_wr_en && (bus.reg_wr_addr == ADDR_IAR);
    ack_vec  = wr_iar ? bus.reg_wr_data[N-1:0] : '0;
    set_vec  = (intr_in & ~prev_q & EDGE_MASK) | (intr_in & ~EDGE_MASK);
    ipr      = isr_q & ier_q;
    any_pend = gie_q & (|ipr);
  end

  // Read mux over the pre-write register values; unmapped offsets and IAR read 0.
  always_comb begin
    rd_mux = 32'h0;
    case (bus.reg_rd_addr)
      ADDR_GIE: rd_mux = {31'h0, gie_q};
      ADDR_IER: rd_mux = 32'(ier_q);
      ADDR_ISR: rd_mux = 32'(isr_q);
      ADDR_IPR: rd_mux = 32'(ipr);
      default:  rd_mux = 32'h0;
    endcase
  end

  // Control/status registers; a new capture overrides an ack on the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      gie_q  <= 1'b0;
      ier_q  <= '0;
      isr_q  <= '0;
      prev_q <= '0;
    end else begin
      if (wr_gie) gie_q <= bus.reg_wr_data[0];
      if (wr_ier) ier_q <= bus.reg_wr_data[N-1:0];
      isr_q  <= (isr_q & ~ack_vec) | set_vec;
      prev_q <= intr_in;
    end
  end

  // Read response stage: one-cycle latency, data held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_rd_data  <= 32'h0;
      bus.reg_rd_valid <= 1'b0;
    end else begin
      bus.reg_rd_valid <= bus.reg_rd_en;
      if (bus.reg_rd_en) bus.reg_rd_data <= rd_mux;
    end
  end

  // Pulse FSM next state; in level mode the irq simply follows any_pend.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (!any_pend) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    irq_active_d = C_IRQ_SENSITIVITY ? any_pend : (state_d == S_PULSE);
  end

  // Pulse FSM state, counter and the registered irq output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      irq     <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq     <= irq_active_d ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
    end
  end

endmodule

// File: tb/tb_flo_intr_ctrl.sv
// Bench for flo_intr_ctrl. Two instances share one stimulus stream:
//   dut_a: all edge sources, level irq.
//   dut_b: source 0 level, sources 1..3 edge, 4-cycle pulse irq.
// A behavioural model predicts register reads and irq; reads are queued at issue
// and popped by a separate monitor when the DUT presents reg_rd_valid.
module tb_flo_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  intr_in;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        irq_a;
  logic        irq_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  flo_intr_ctrl_if bus_a ();
  flo_intr_ctrl_if bus_b ();

  assign bus_a.reg_wr_en   = wr_en;
  assign bus_a.reg_wr_addr = wr_addr;
  assign bus_a.reg_wr_data = wr_data;
  assign bus_a.reg_rd_en   = rd_en;
  assign bus_a.reg_rd_addr = rd_addr;
  assign bus_b.reg_wr_en   = wr_en;
  assign bus_b.reg_wr_addr = wr_addr;
  assign bus_b.reg_wr_data = wr_data;
  assign bus_b.reg_rd_en   = rd_en;
  assign bus_b.reg_rd_addr = rd_addr;

  flo_intr_ctrl #(
    .C_NUM_OF_INTR(4), .C_INTR_SENSITIVITY(32'hFFFFFFFF), .C_IRQ_SENSITIVITY(1'b1),
    .C_IRQ_ACTIVE_STATE(1'b1), .C_IRQ_PULSE_CYCLES(4)
  ) dut_a (.clk(clk), .rst(rst), .intr_in(intr_in), .bus(bus_a), .irq(irq_a));

  flo_intr_ctrl #(
    .C_NUM_OF_INTR(4), .C_INTR_SENSITIVITY(32'hFFFFFFFE), .C_IRQ_SENSITIVITY(1'b0),
    .C_IRQ_ACTIVE_STATE(1'b1), .C_IRQ_PULSE_CYCLES(4)
  ) dut_b (.clk(clk), .rst(rst), .intr_in(intr_in), .bus(bus_b), .irq(irq_b));

  // ---------------- reference model ----------------
  logic [3:0]  edge_src [2] = '{4'hF, 4'hE};
  bit          pulse_md [2] = '{1'b0, 1'b1};
  bit          m_gie  [2];
  logic [3:0]  m_ier  [2];
  logic [3:0]  m_isr  [2];
  logic [3:0]  m_prev [2];
  bit          m_busy [2];
  int          m_left [2];
  bit          m_irq  [2];
  bit          m_rdv;
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];

  function automatic logic [31:0] reg_value(input int d, input logic [4:0] a);
    case (a)
      5'h00:   return {31'h0, m_gie[d]};
      5'h04:   return {28'h0, m_ier[d]};
      5'h08:   return {28'h0, m_isr[d]};
      5'h10:   return {28'h0, m_isr[d] & m_ier[d]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit         pend;
    logic [3:0] ack;
    logic [3:0] captured;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_gie[d] = 1'b0; m_ier[d] = 4'h0; m_isr[d] = 4'h0; m_prev[d] = 4'h0;
        m_busy[d] = 1'b0; m_left[d] = 0; m_irq[d] = 1'b0;
      end else begin
        pend = m_gie[d] && ((m_isr[d] & m_ier[d]) != 4'h0);
        if (rd_en) begin
          if (d == 0) q_a.push_back(reg_value(0, rd_addr));
          else        q_b.push_back(reg_value(1, rd_addr));
        end
        captured = 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (edge_src[d][i]) captured[i] = intr_in[i] && !m_prev[d][i];
          else                captured[i] = intr_in[i];
        end
        ack = (wr_en && wr_addr == 5'h0C) ? wr_data[3:0] : 4'h0;
        if (wr_en && wr_addr == 5'h00) m_gie[d] = wr_data[0];
        if (wr_en && wr_addr == 5'h04) m_ier[d] = wr_data[3:0];
        m_isr[d]  = (m_isr[d] & ~ack) | captured;
        m_prev[d] = intr_in;
        if (!pulse_md[d]) begin
          m_irq[d] = pend;
        end else begin
          // remaining high cycles; a new pulse needs pend to drop first
          if (!m_busy[d]) begin
            if (pend) begin m_busy[d] = 1'b1; m_left[d] = 4; end
          end else if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
          end else if (!pend) begin
            m_busy[d] = 1'b0;
          end
          m_irq[d] = (m_left[d] > 0);
        end
      end
    end
    m_rdv = rd_en && !rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (mon_en) begin
      chk("rd_valid_a", {31'h0, bus_a.reg_rd_valid}, {31'h0, m_rdv});
      chk("rd_valid_b", {31'h0, bus_b.reg_rd_valid}, {31'h0, m_rdv});
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        if (bus_a.reg_rd_valid) chk("rd_data_a", bus_a.reg_rd_data, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        if (bus_b.reg_rd_valid) chk("rd_data_b", bus_b.reg_rd_data, e);
      end
      chk("irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
      chk("irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_src(input int k);
    intr_in = 4'h0;
    intr_in[k] = 1'b1;
    @(negedge clk);
    intr_in = 4'h0;
  endtask

  task automatic count_irq_b(input int window, output int cnt);
    cnt = 0;
    repeat (window) begin
      @(negedge clk);
      if (irq_b) cnt++;
    end
  endtask

  initial begin : stim
    int cnt;
    rst = 1'b1; intr_in = 4'h0; wr_en = 1'b0; wr_addr = 5'h0; wr_data = 32'h0;
    rd_en = 1'b0; rd_addr = 5'h0;
    @(negedge clk);
    mon_en = 1'b1;
    idle(2);
    rst = 1'b0;

    // reset values, back-to-back reads
    rd(5'h00); rd(5'h04); rd(5'h08); rd(5'h10);
    idle(1);

    // single edge source enabled, then acked
    wr(5'h00, 32'h1); wr(5'h04, 32'h1);
    pulse_src(0);
    idle(3);
    rd(5'h08); rd(5'h10);
    wr(5'h0C, 32'h1);
    idle(2);
    rd(5'h10);
    idle(6);

    // captured but masked, then enabled
    wr(5'h04, 32'h0);
    pulse_src(2);
    idle(2);
    rd(5'h08); rd(5'h10);
    idle(3);
    wr(5'h04, 32'h4);
    idle(3);
    wr(5'h0C, 32'hF);
    idle(6);

    // ack and new edge on bit 1 in the same cycle
    pulse_src(1);
    idle(2);
    intr_in = 4'b0010;
    wr(5'h0C, 32'h2);
    intr_in = 4'h0;
    rd(5'h08);
    wr(5'h0C, 32'hF);
    idle(6);

    // source 0 held high while acked
    intr_in = 4'b0001;
    idle(2);
    wr(5'h0C, 32'h1);
    rd(5'h08);
    intr_in = 4'h0;
    idle(1);
    wr(5'h0C, 32'hF);
    idle(8);

    // pulse width, no re-trigger during WAIT, re-arm after full ack
    wr(5'h04, 32'hF);
    idle(2);
    pulse_src(3);
    count_irq_b(15, cnt);
    chk("pulse_len", cnt, 4);
    pulse_src(2);
    count_irq_b(10, cnt);
    chk("no_retrigger", cnt, 0);
    wr(5'h0C, 32'hF);
    idle(2);
    pulse_src(1);
    count_irq_b(15, cnt);
    chk("rearm_pulse_len", cnt, 4);
    wr(5'h0C, 32'hF);
    idle(4);

    // reset in the middle of a pulse
    pulse_src(3);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("irq_b_after_rst", {31'h0, irq_b}, 32'h0);
    rst = 1'b0;
    rd(5'h00); rd(5'h04); rd(5'h08); rd(5'h10);
    wr(5'h04, 32'hFFFFFFFF);
    rd(5'h04);
    rd(5'h14);
    wr(5'h08, 32'hF);
    rd(5'h08);
    idle(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      intr_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      wr_en   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: wr_addr = 5'h00;
        1: wr_addr = 5'h04;
        2, 3: wr_addr = 5'h0C;
        4: wr_addr = 5'h08;
        5: wr_addr = 5'h10;
        default: wr_addr = 5'($urandom);
      endcase
      wr_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rd_en   = ($urandom_range(0, 1) == 0);
      rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(4 * $urandom_range(0, 4));
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; intr_in = 4'h0;
    idle(3);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
